// File: rtl/codec_cfg_pkg.sv
// Codec configuration package: register map, power-on init table, scheduler state.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package codec_cfg_pkg;

  // Codec register addresses (7-bit)
  localparam logic [6:0] R_LINE_L  = 7'h00;
  localparam logic [6:0] R_ANALOG  = 7'h04;
  localparam logic [6:0] R_DIGITAL = 7'h05;
  localparam logic [6:0] R_POWER   = 7'h06;
  localparam logic [6:0] R_IFACE   = 7'h07;
  localparam logic [6:0] R_SAMPLE  = 7'h08;
  localparam logic [6:0] R_ACTIVE  = 7'h09;
  localparam logic [6:0] R_RESET   = 7'h0F;

  localparam int INIT_DEPTH = 7;
  localparam int IDX_W      = $clog2(INIT_DEPTH);

  // Power-on sequence: reset the codec, power up the used blocks, route the
  // analog/digital paths, set the interface format and rate, then activate.
  localparam logic [15:0] INIT_TABLE [INIT_DEPTH] = '{
    {R_RESET,   9'h000},
    {R_POWER,   9'h061},
    {R_ANALOG,  9'h014},
    {R_DIGITAL, 9'h000},
    {R_IFACE,   9'h042},
    {R_SAMPLE,  9'h000},
    {R_ACTIVE,  9'h001}
  };

  typedef enum logic [1:0] {
    S_POWERUP = 2'd0,
    S_INIT    = 2'd1,
    S_USER    = 2'd2,
    S_IDLE    = 2'd3
  } state_t;

  function automatic logic [15:0] pack_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/codec_reg_scheduler_if.sv
// Request port (requester -> scheduler) and write port (scheduler -> I2C engine).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both ports; slave = scheduler side, master = environment side.
interface codec_reg_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic [8:0]  req_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_reg_and_data;

  modport slave (
    input  req_valid, req_addr, req_data, wr_ready,
    output req_ready, wr_valid, wr_reg_and_data
  );

  modport master (
    output req_valid, req_addr, req_data, wr_ready,
    input  req_ready, wr_valid, wr_reg_and_data
  );
endinterface

// File: rtl/codec_init_rom.sv
// Combinational lookup of an init-table word by index; out-of-range returns 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: idx (table index in), word ({reg[6:0], data[8:0]} out).
module codec_init_rom
  import codec_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [15:0]      word
);

  always_comb begin
    word = '0;
    if (int'(idx) < INIT_DEPTH) begin
      word = INIT_TABLE[idx];
    end
  end

endmodule

// File: rtl/codec_reg_scheduler.sv
// Sequences codec register writes: power-up wait, init table walk, then runtime requests.
// Latency: first write POWERUP_CYCLES edges after reset; request in IDLE offered next cycle.
// Backpressure: offered word held stable until wr_ready; one-entry request buffer, req_ready = !buf_full.
// Ports: i2c_clk, rst_n (async low), reinit (pulse), bus (req_* in / wr_* out),
//        init_done (init walk complete), busy (low only in IDLE with empty buffer).
// NUM_INIT must lie in 1..INIT_DEPTH.
module codec_reg_scheduler
  import codec_cfg_pkg::*;
#(
  parameter int POWERUP_CYCLES = 200,
  parameter int NUM_INIT       = 7
) (
  input  logic                  i2c_clk,
  input  logic                  rst_n,
  input  logic                  reinit,
  codec_reg_scheduler_if.slave  bus,
  output logic                  init_done,
  output logic                  busy
);

  localparam int                CNT_W    = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             buf_full;
  logic [6:0]       buf_addr;
  logic [8:0]       buf_data;
  logic             reinit_pend;
  logic             wr_valid;
  logic [15:0]      wr_word;

  logic             wr_fire;
  logic             req_fire;
  logic             reinit_now;
  logic             have_req;
  logic [15:0]      user_word;
  logic [IDX_W-1:0] rom_idx;
  logic [15:0]      rom_word;

  assign wr_fire    = wr_valid & bus.wr_ready;
  assign req_fire   = bus.req_valid & ~buf_full;
  // A latched reinit or one arriving on the transfer edge both restart the walk.
  assign reinit_now = reinit_pend | reinit;
  // A request accepted this very edge counts as buffered so no bubble is inserted.
  assign have_req   = buf_full | req_fire;
  assign user_word  = buf_full ? pack_word(buf_addr, buf_data)
                               : pack_word(bus.req_addr, bus.req_data);

  // The ROM is addressed with the index of the word to load on the coming edge:
  // idx+1 when advancing mid-walk, entry 0 on every entry into INIT.
  always_comb begin
    rom_idx = '0;
    if (state == S_INIT && !reinit_now && idx != LAST_IDX) begin
      rom_idx = idx + 1'b1;
    end
  end

  codec_init_rom u_rom (
    .idx  (rom_idx),
    .word (rom_word)
  );

  assign bus.req_ready       = ~buf_full;
  assign bus.wr_valid        = wr_valid;
  assign bus.wr_reg_and_data = wr_word;
  assign busy                = !(state == S_IDLE && !buf_full);

  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_POWERUP;
      cnt         <= '0;
      idx         <= '0;
      buf_full    <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      reinit_pend <= 1'b0;
      init_done   <= 1'b0;
      wr_valid    <= 1'b0;
      wr_word     <= '0;
    end else begin
      // Request buffer: loads in any state, drains only when the user word transfers.
      if (req_fire) begin
        buf_full <= 1'b1;
        buf_addr <= bus.req_addr;
        buf_data <= bus.req_data;
      end else if (state == S_USER && wr_fire) begin
        buf_full <= 1'b0;
      end

      case (state)
        S_POWERUP: begin
          if (cnt == LAST_CNT) begin
            state    <= S_INIT;
            idx      <= '0;
            wr_valid <= 1'b1;
            wr_word  <= rom_word;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_INIT: begin
          if (wr_fire) begin
            if (reinit_now) begin
              idx         <= '0;
              wr_word     <= rom_word;
              reinit_pend <= 1'b0;
              init_done   <= 1'b0;
            end else if (idx == LAST_IDX) begin
              init_done <= 1'b1;
              if (have_req) begin
                state   <= S_USER;
                wr_word <= user_word;
              end else begin
                state    <= S_IDLE;
                wr_valid <= 1'b0;
              end
            end else begin
              idx     <= idx + 1'b1;
              wr_word <= rom_word;
            end
          end else if (reinit) begin
            // Offered word must not be withdrawn; restart after it transfers.
            reinit_pend <= 1'b1;
            init_done   <= 1'b0;
          end
        end

        S_USER: begin
          if (wr_fire) begin
            if (reinit_now) begin
              state       <= S_INIT;
              idx         <= '0;
              wr_word     <= rom_word;
              reinit_pend <= 1'b0;
              init_done   <= 1'b0;
            end else begin
              state    <= S_IDLE;
              wr_valid <= 1'b0;
            end
          end else if (reinit) begin
            reinit_pend <= 1'b1;
            init_done   <= 1'b0;
          end
        end

        S_IDLE: begin
          // reinit wins over a simultaneous request; the request stays buffered.
          if (reinit) begin
            state     <= S_INIT;
            idx       <= '0;
            wr_valid  <= 1'b1;
            wr_word   <= rom_word;
            init_done <= 1'b0;
          end else if (have_req) begin
            state    <= S_USER;
            wr_valid <= 1'b1;
            wr_word  <= user_word;
          end
        end

        default: state <= S_POWERUP;
      endcase
    end
  end

endmodule
